// File: rtl/jtag_tap_ctrl.sv
// ============================================================================
//  Module   : jtag_tap_ctrl
//  Brief    : IEEE 1149.1 TAP controller with a 2-bit IR, bypass register and
//             boundary-scan / internal-scan DR control generation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_ctrl (
   input  logic       TCLK,
   input  logic       TRST,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       TDO_BSR,
   input  logic       TDO_ISR,
   output logic       TDO,
   output logic [1:0] inst,
   output logic       clockdr_bs,
   output logic       shiftdr_bs,
   output logic       updatedr_bs,
   output logic       clockdr_is,
   output logic       shiftdr_is,
   output logic       updatedr_is,
   output logic [3:0] tap_state
);

   typedef enum logic [3:0] {
      TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
      SHDR  = 4'h2, EX1DR = 4'h1, PADR  = 4'h3, EX2DR = 4'h0,
      UPDR  = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
      EX1IR = 4'h9, PAIR  = 4'hB, EX2IR = 4'h8, UPIR  = 4'hD
   } tap_state_t;

   localparam logic [1:0] c_extest  = 2'b00;
   localparam logic [1:0] c_sample  = 2'b01;
   localparam logic [1:0] c_bypass  = 2'b10;
   localparam logic [1:0] c_intscan = 2'b11;

   tap_state_t r_state;
   tap_state_t w_next;
   logic [1:0] r_ir_sh;
   logic [1:0] r_inst;
   logic       r_bypass;
   logic       w_sel_bs;
   logic       w_sel_is;

   always_ff @(posedge TCLK) begin
      if (TRST) begin
         r_state  <= TLR;
         r_inst   <= c_bypass;
         r_ir_sh  <= 2'b01;
         r_bypass <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            TLR:   r_inst  <= c_bypass;
            CAPIR: r_ir_sh <= 2'b01;
            SHIR:  r_ir_sh <= {TDI, r_ir_sh[1]};
            UPIR:  r_inst  <= r_ir_sh;
            CAPDR: r_bypass <= 1'b0;
            SHDR:  if (r_inst == c_bypass) r_bypass <= TDI;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         TLR:   w_next = TMS ? TLR   : RTI;
         RTI:   w_next = TMS ? SELDR : RTI;
         SELDR: w_next = TMS ? SELIR : CAPDR;
         CAPDR: w_next = TMS ? EX1DR : SHDR;
         SHDR:  w_next = TMS ? EX1DR : SHDR;
         EX1DR: w_next = TMS ? UPDR  : PADR;
         PADR:  w_next = TMS ? EX2DR : PADR;
         EX2DR: w_next = TMS ? UPDR  : SHDR;
         UPDR:  w_next = TMS ? SELDR : RTI;
         SELIR: w_next = TMS ? TLR   : CAPIR;
         CAPIR: w_next = TMS ? EX1IR : SHIR;
         SHIR:  w_next = TMS ? EX1IR : SHIR;
         EX1IR: w_next = TMS ? UPIR  : PAIR;
         PAIR:  w_next = TMS ? EX2IR : PAIR;
         EX2IR: w_next = TMS ? UPIR  : SHIR;
         UPIR:  w_next = TMS ? SELDR : RTI;
         default: w_next = TLR;
      endcase
   end

   // EXTEST and SAMPLE both route the DR scan to the boundary-scan chain
   assign w_sel_bs = (r_inst == c_extest) || (r_inst == c_sample);
   assign w_sel_is = (r_inst == c_intscan);

   always_comb begin
      clockdr_bs  = 1'b0;
      shiftdr_bs  = 1'b0;
      updatedr_bs = 1'b0;
      clockdr_is  = 1'b0;
      shiftdr_is  = 1'b0;
      updatedr_is = 1'b0;
      TDO         = 1'b0;
      case (r_state)
         CAPDR: begin
            clockdr_bs = w_sel_bs;
            clockdr_is = w_sel_is;
         end
         SHDR: begin
            clockdr_bs = w_sel_bs;
            clockdr_is = w_sel_is;
            shiftdr_bs = w_sel_bs;
            shiftdr_is = w_sel_is;
            if (w_sel_bs)      TDO = TDO_BSR;
            else if (w_sel_is) TDO = TDO_ISR;
            else               TDO = r_bypass;
         end
         UPDR: begin
            updatedr_bs = w_sel_bs;
            updatedr_is = w_sel_is;
         end
         SHIR: TDO = r_ir_sh[0];
         default: ;
      endcase
   end

   assign inst      = r_inst;
   assign tap_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
// ============================================================================
//  Module   : tb_jtag_tap_ctrl
//  Brief    : Directed self-checking bench for jtag_tap_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap_ctrl;

   logic       TCLK = 1'b0;
   logic       TRST, TMS, TDI, TDO_BSR, TDO_ISR;
   logic       TDO;
   logic [1:0] inst;
   logic       clockdr_bs, shiftdr_bs, updatedr_bs;
   logic       clockdr_is, shiftdr_is, updatedr_is;
   logic [3:0] tap_state;
   int         checks   = 0;
   int         failures = 0;

   jtag_tap_ctrl dut (
      .TCLK        (TCLK),
      .TRST        (TRST),
      .TMS         (TMS),
      .TDI         (TDI),
      .TDO_BSR     (TDO_BSR),
      .TDO_ISR     (TDO_ISR),
      .TDO         (TDO),
      .inst        (inst),
      .clockdr_bs  (clockdr_bs),
      .shiftdr_bs  (shiftdr_bs),
      .updatedr_bs (updatedr_bs),
      .clockdr_is  (clockdr_is),
      .shiftdr_is  (shiftdr_is),
      .updatedr_is (updatedr_is),
      .tap_state   (tap_state)
   );

   always #5 TCLK = ~TCLK;

   // {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is, updatedr_is}
   logic [5:0] ctl;
   assign ctl = {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is, updatedr_is};

   task automatic step(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; TDO_BSR = 1'b0; TDO_ISR = 1'b0;
      #2;
      step(1'b1, 1'b0);
      chk("rst_state", 8'(tap_state), 8'hF);
      chk("rst_inst",  8'(inst), 8'h2);
      chk("rst_ctl",   8'(ctl), 8'h00);
      chk("rst_tdo",   8'(TDO), 8'h0);
      TRST = 1'b0;

      // BYPASS DR scan
      step(0, 0); chk("byp_rti", 8'(tap_state), 8'hC);
      step(1, 0); chk("byp_seldr", 8'(tap_state), 8'h7);
      step(0, 0); chk("byp_capdr", 8'(tap_state), 8'h6);
      chk("byp_capdr_ctl", 8'(ctl), 8'h00);
      step(0, 0); chk("byp_shdr", 8'(tap_state), 8'h2);
      chk("byp_tdo0", 8'(TDO), 8'h0);
      step(0, 1); chk("byp_tdo1", 8'(TDO), 8'h1);
      step(0, 0); chk("byp_tdo2", 8'(TDO), 8'h0);
      step(0, 1); chk("byp_tdo3", 8'(TDO), 8'h1);
      chk("byp_ctl", 8'(ctl), 8'h00);

      // Five TMS=1 from SHDR reach TLR
      step(1, 0); step(1, 0); step(1, 0); step(1, 0);
      chk("tlr_not_yet", 8'(tap_state), 8'h4);
      step(1, 0);
      chk("tlr_reached", 8'(tap_state), 8'hF);
      chk("tlr_inst", 8'(inst), 8'h2);

      // IR load of INTSCAN (11)
      step(0, 0); step(1, 0); step(1, 0);
      chk("ir_selir", 8'(tap_state), 8'h4);
      step(0, 0); chk("ir_capir", 8'(tap_state), 8'hE);
      step(0, 0); chk("ir_shir", 8'(tap_state), 8'hA);
      chk("ir_tdo_a", 8'(TDO), 8'h1);
      chk("ir_ctl", 8'(ctl), 8'h00);
      step(0, 1); chk("ir_tdo_b", 8'(TDO), 8'h0);
      step(1, 1); chk("ir_ex1ir", 8'(tap_state), 8'h9);
      step(1, 0); chk("ir_upir", 8'(tap_state), 8'hD);
      chk("ir_inst_hold", 8'(inst), 8'h2);
      step(0, 0); chk("ir_inst_new", 8'(inst), 8'h3);
      chk("ir_rti", 8'(tap_state), 8'hC);

      // INTSCAN DR scan
      TDO_ISR = 1'b1;
      step(1, 0); step(0, 0);
      chk("is_capdr_ctl", 8'(ctl), 8'h04);
      chk("is_capdr_tdo", 8'(TDO), 8'h0);
      step(0, 0);
      chk("is_shdr_ctl", 8'(ctl), 8'h06);
      chk("is_tdo_hi", 8'(TDO), 8'h1);
      TDO_ISR = 1'b0; #1;
      chk("is_tdo_lo", 8'(TDO), 8'h0);
      step(0, 0); step(1, 0);
      chk("is_ex1dr_ctl", 8'(ctl), 8'h00);
      step(1, 0);
      chk("is_updr", 8'(tap_state), 8'h5);
      chk("is_updr_ctl", 8'(ctl), 8'h01);
      step(0, 0);
      chk("is_post_ctl", 8'(ctl), 8'h00);
      chk("is_inst_kept", 8'(inst), 8'h3);

      // IR load of EXTEST (00)
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      step(0, 0); step(1, 0); step(1, 0); step(0, 0);
      chk("ex_inst", 8'(inst), 8'h0);

      // EXTEST DR scan with pause
      TDO_BSR = 1'b1;
      step(1, 0); step(0, 0); step(0, 0);
      chk("ex_shdr_ctl", 8'(ctl), 8'h30);
      chk("ex_tdo", 8'(TDO), 8'h1);
      step(1, 0); chk("ex_ex1dr_ctl", 8'(ctl), 8'h00);
      step(0, 0); chk("ex_padr", 8'(tap_state), 8'h3);
      chk("ex_padr_ctl", 8'(ctl), 8'h00);
      chk("ex_padr_tdo", 8'(TDO), 8'h0);
      step(0, 0); step(0, 0);
      chk("ex_padr3", 8'(tap_state), 8'h3);
      step(1, 0); chk("ex_ex2dr", 8'(tap_state), 8'h0);
      chk("ex_ex2dr_ctl", 8'(ctl), 8'h00);
      step(0, 0); chk("ex_resume_ctl", 8'(ctl), 8'h30);
      step(1, 0); step(1, 0);
      chk("ex_updr_ctl", 8'(ctl), 8'h08);

      // Reset during IR shift
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      chk("ab_shir", 8'(tap_state), 8'hA);
      step(0, 1);
      chk("ab_inst_pre", 8'(inst), 8'h0);
      TRST = 1'b1;
      step(0, 0);
      chk("ab_state", 8'(tap_state), 8'hF);
      chk("ab_inst", 8'(inst), 8'h2);
      chk("ab_ctl", 8'(ctl), 8'h00);
      chk("ab_tdo", 8'(TDO), 8'h0);
      TRST = 1'b0;
      step(0, 0);
      chk("ab_rti", 8'(tap_state), 8'hC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
